// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, the NOP word and instruction field positions.
// Pure constants plus one helper; no state, no latency, no flow control.
package cpu_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // J-format target: region bits come from the sequential PC, not the jump's own PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle latch of fetched word and its PC+4.
// Flush clears to a NOP bubble and beats hold; hold freezes contents.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= 32'h0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= 32'h0;
        end else if (!i_hold) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC mux with zero-penalty J, IF/ID latch; one-cycle latency.
// Stall holds PC/IF/ID/count; redirect overrides stall and flushes IF/ID (one bubble).
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic        w_is_jump;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_next_pc;
    logic        w_advance;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_is_jump      = (imem_data[OPC_MSB:OPC_LSB] == OPC_J);
    assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;
    assign w_advance      = !redirect && !stall;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (redirect)
            w_next_pc = w_redirect_tgt;
        else if (stall)
            w_next_pc = r_pc;
        else if (w_is_jump)
            w_next_pc = jump_target(w_pc_plus4, imem_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'h0;
        end else begin
            r_pc <= w_next_pc;
            if (w_advance)
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Jump words are latched like any other instruction: there is no delay slot to squash.
    if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .i_hold     (stall),
        .i_flush    (redirect),
        .i_instr    (imem_data),
        .i_pc_plus4 (w_pc_plus4),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc_plus4 (id_pc_plus4)
    );

    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;

    assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
    assign id_rs     = id_instr[RS_MSB:RS_LSB];
    assign id_rt     = id_instr[RT_MSB:RT_LSB];
    assign id_rd     = id_instr[RD_MSB:RD_LSB];
    assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];
    assign id_imm16  = id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: table of one-cycle steps plus a mid-cycle reset sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [31:0] fetch_count;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_funct    (id_funct),
        .id_imm16    (id_imm16),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] imem;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic        chk_pp4;
        logic [31:0] e_pp4;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] imem, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_instr,
                       input logic chk_pp4, input logic [31:0] e_pp4,
                       input logic [31:0] e_cnt);
        vec_t v;
        v.stall = st;   v.redirect = rd;  v.rpc = rpc;       v.imem = imem;
        v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr;
        v.chk_pp4 = chk_pp4; v.e_pp4 = e_pp4; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    // Field expectations are written out by hand as {opcode, rs, rt, rd, funct, imm16}.
    task automatic chk_fields(input string tag, input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [5:0] fn, input logic [15:0] imm);
        chk({tag, ".opcode"}, {26'h0, id_opcode}, {26'h0, op});
        chk({tag, ".rs"},     {27'h0, id_rs},     {27'h0, rs});
        chk({tag, ".rt"},     {27'h0, id_rt},     {27'h0, rt});
        chk({tag, ".rd"},     {27'h0, id_rd},     {27'h0, rd});
        chk({tag, ".funct"},  {26'h0, id_funct},  {26'h0, fn});
        chk({tag, ".imm16"},  {16'h0, id_imm16},  {16'h0, imm});
    endtask

    initial begin
        //   st rd  rpc           imem          addr          vld instr          cp pp4           cnt
        add(0, 0, 32'h0,        32'h0000_0000, 32'h0000_0004, 1, 32'h0000_0000, 1, 32'h0000_0004, 1);
        add(0, 0, 32'h0,        32'h2002_0005, 32'h0000_0008, 1, 32'h2002_0005, 1, 32'h0000_0008, 2);
        add(1, 0, 32'h0,        32'hDEAD_BEEF, 32'h0000_0008, 1, 32'h2002_0005, 1, 32'h0000_0008, 2);
        add(1, 0, 32'h0,        32'h0800_0100, 32'h0000_0008, 1, 32'h2002_0005, 1, 32'h0000_0008, 2);
        add(1, 0, 32'h0,        32'hDEAD_BEEF, 32'h0000_0008, 1, 32'h2002_0005, 1, 32'h0000_0008, 2);
        add(0, 0, 32'h0,        32'h0000_0000, 32'h0000_000C, 1, 32'h0000_0000, 1, 32'h0000_000C, 3);
        add(0, 1, 32'h0000_0020,32'h1234_5678, 32'h0000_0020, 0, 32'h0000_0000, 0, 32'h0,         3);
        add(0, 0, 32'h0,        32'h0800_0010, 32'h0000_0040, 1, 32'h0800_0010, 1, 32'h0000_0024, 4);
        add(0, 0, 32'h0,        32'h0128_5020, 32'h0000_0044, 1, 32'h0128_5020, 1, 32'h0000_0044, 5);
        add(1, 1, 32'h0000_1003,32'h0800_0100, 32'h0000_1000, 0, 32'h0000_0000, 0, 32'h0,         5);
        add(0, 0, 32'h0,        32'h8C22_0004, 32'h0000_1004, 1, 32'h8C22_0004, 1, 32'h0000_1004, 6);
        add(0, 1, 32'hFFFF_FFFC,32'h0,         32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 32'h0,         6);
        add(0, 0, 32'h0,        32'hFFFF_FFFF, 32'h0000_0000, 1, 32'hFFFF_FFFF, 1, 32'h0000_0000, 7);
        add(0, 0, 32'h0,        32'h0BFF_FFFF, 32'h0FFF_FFFC, 1, 32'h0BFF_FFFF, 1, 32'h0000_0004, 8);
        add(0, 0, 32'h0,        32'h0000_0000, 32'h1000_0000, 1, 32'h0000_0000, 1, 32'h1000_0000, 9);
        add(0, 0, 32'h0,        32'h0800_0001, 32'h1000_0004, 1, 32'h0800_0001, 1, 32'h1000_0004, 10);
        add(1, 0, 32'h0,        32'h0800_0100, 32'h1000_0004, 1, 32'h0800_0001, 1, 32'h1000_0004, 10);
        add(0, 1, 32'h0000_0080,32'h0800_0100, 32'h0000_0080, 0, 32'h0000_0000, 0, 32'h0,         10);
        add(0, 0, 32'h0,        32'h0C00_0010, 32'h0000_0084, 1, 32'h0C00_0010, 1, 32'h0000_0084, 11);

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_data = 32'h0;
        #2;
        chk("rst.addr",  imem_addr,   32'h0);
        chk("rst.vld",   {31'h0, id_valid}, 32'h0);
        chk("rst.instr", id_instr,    32'h0);
        chk("rst.pp4",   id_pc_plus4, 32'h0);
        chk("rst.cnt",   fetch_count, 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            stall = tbl[i].stall; redirect = tbl[i].redirect;
            redirect_pc = tbl[i].rpc; imem_data = tbl[i].imem;
            @(posedge clk); #1;
            chk($sformatf("v%0d.addr", i),  imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d.vld", i),   {31'h0, id_valid}, {31'h0, tbl[i].e_vld});
            chk($sformatf("v%0d.instr", i), id_instr,  tbl[i].e_instr);
            if (tbl[i].chk_pp4)
                chk($sformatf("v%0d.pp4", i), id_pc_plus4, tbl[i].e_pp4);
            chk($sformatf("v%0d.cnt", i),   fetch_count, tbl[i].e_cnt);
            if (i == 8)  chk_fields("add",  6'h00, 5'd9, 5'd8, 5'd10, 6'h20, 16'h5020);
            if (i == 9)  chk_fields("bub",  6'h00, 5'd0, 5'd0, 5'd0,  6'h00, 16'h0000);
            if (i == 10) chk_fields("lw",   6'h23, 5'd1, 5'd2, 5'd0,  6'h04, 16'h0004);
        end

        // Asynchronous reset pulsed between edges, then the first fetch restarts at RESET_PC.
        stall = 1'b0; redirect = 1'b0; imem_data = 32'h0000_0000;
        @(posedge clk); #1;
        chk("pre.cnt", fetch_count, 32'd12);
        #2 reset = 1'b1;
        #1;
        chk("arst.addr",  imem_addr,   32'h0);
        chk("arst.vld",   {31'h0, id_valid}, 32'h0);
        chk("arst.instr", id_instr,    32'h0);
        chk("arst.pp4",   id_pc_plus4, 32'h0);
        chk("arst.cnt",   fetch_count, 32'h0);
        chk_fields("arst", 6'h00, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000);
        #1 reset = 1'b0;
        imem_data = 32'h2003_0007;
        #1;
        chk("post.addr0", imem_addr, 32'h0);
        @(posedge clk); #1;
        chk("post.addr",  imem_addr,   32'h4);
        chk("post.vld",   {31'h0, id_valid}, 32'h1);
        chk("post.instr", id_instr,    32'h2003_0007);
        chk("post.pp4",   id_pc_plus4, 32'h4);
        chk("post.cnt",   fetch_count, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU, directly upstream of the decode/register-write stage. Owns the program counter, drives the instruction-memory address, resolves unconditional jumps in-stage with zero penalty, and latches the fetched word into the IF/ID pipeline register. The register's outputs are split into Rs/Rt/Rd/imm16 fields that feed decode directly. Honours stall and redirect/flush requests from later stages.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents (hazard from decode/execute)
- redirect  in  1  taken branch resolved downstream; load redirect_pc
- redirect_pc  in  32  branch target; bits [1:0] ignored (forced 0)
- imem_addr  out  32  current PC, combinational from PC register
- imem_data  in  32  instruction word for imem_addr, valid same cycle (combinational memory)
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  latched instruction word
- id_pc_plus4  out  32  PC+4 of the latched instruction
- id_opcode  out  6  id_instr[31:26]
- id_rs  out  5  id_instr[25:21]
- id_rt  out  5  id_instr[20:16]
- id_rd  out  5  id_instr[15:11]
- id_funct  out  6  id_instr[5:0]
- id_imm16  out  16  id_instr[15:0]
- fetch_count  out  32  number of valid instructions latched into IF/ID since reset

## Operation
- Next-PC priority, highest first: reset → redirect → stall → jump → PC+4.
- reset: PC = RESET_PC, id_valid = 0, id_instr = 0, id_pc_plus4 = 0, fetch_count = 0. All field outputs read 0.
- redirect: PC ← {redirect_pc[31:2], 2'b00}; IF/ID flushed (id_valid = 0, id_instr = 0). Applies even if stall is high. fetch_count unchanged.
- stall, no redirect: PC, IF/ID and fetch_count all hold.
- Jump: imem_data opcode = 6'b000010 (J). Next PC = {pc_plus4[31:28], imem_data[25:0], 2'b00}. The J word itself is latched into IF/ID as valid. There is no delay slot.
- Otherwise: PC ← PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Normal latch: id_instr ← imem_data, id_pc_plus4 ← PC+4, id_valid ← 1, fetch_count ← fetch_count+1. fetch_count wraps at 2^32.
- Field outputs are pure slices of id_instr. A flushed slot decodes as NOP (all zero).

## Timing
- Fetch latency: one cycle. The word at imem_addr in cycle N appears on id_* in cycle N+1.
- Redirect asserted in cycle N: imem_addr = target in N+1, and id_valid = 0 in N+1. The first target instruction is on id_* in N+2, so the branch penalty is one bubble.
- Jump fetched in cycle N: imem_addr = jump target in N+1, with no bubble.
- Stall in cycle N: imem_addr and id_* in N+1 equal their values in N.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock. After deassertion, the first fetch is at RESET_PC on the next rising edge.

## Structure
- Shared package cpu_pkg holds:
  - OPC_J = 6'b000010 and the other opcode constants
  - NOP_WORD = 32'h0
  - field-position localparams for rs, rt, rd, imm16, funct
- Sub-module if_id_reg holds the IF/ID pipeline register with valid, stall (hold) and flush (clear) controls.
- fetch_stage contains:
  - the PC register
  - next-PC mux
  - jump detection
  - fetch_count
  - one if_id_reg instance

## Test plan
- Reset then free-run, imem returning 32'h0000_0000 → imem_addr steps 0, 4, 8, 0xC. id_pc_plus4 lags imem_addr by one cycle, at +4. fetch_count = 3 after three clocks.
- Word 32'h0800_0010 (J) at PC 0x20 → imem_addr = 0x40 in the next cycle. id_instr = 0x0800_0010 with id_valid = 1, and no bubble.
- redirect = 1 with redirect_pc = 0x1003 while stall = 1 → imem_addr = 0x1000 in the next cycle. id_valid = 0 and id_instr = 0. fetch_count is unchanged.
- stall held for 3 cycles at PC 0x8 → imem_addr stays 0x8 and id_* frozen. Release resumes fetching at 0xC.
- PC forced via redirect to 0xFFFF_FFFC → next imem_addr = 0. id_pc_plus4 = 0 for that word.
- reset pulsed between clock edges during run → all outputs zero immediately. First post-reset fetch is at RESET_PC.
